fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants used by the fetch path and the rest of the core.
package fetch_unit_pkg;

  localparam int          INSTR_WIDTH  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  // Memory map regions
  localparam logic [31:0] MEM_ROM = 32'h0000_0000;
  localparam logic [31:0] MEM_RAM = 32'h8000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch buffer: head entry is visible while not empty; a flush
// empties it in one cycle and wins over any push/pop in the same cycle.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle
  assign do_push  = push && (!full || do_pop);
  // Empty buffer presents zeros so the decode-side outputs read 0 after reset
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until pointed at by rd_ptr
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches under a credit limit,
// buffers in-order responses with their PCs, and handles redirects by
// flushing the buffer and discarding responses of requests already in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instruction,
  output logic [XLEN-1:0]        id_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = XLEN + INSTR_WIDTH;

  logic [XLEN-1:0] fetch_pc;     // address of the next request
  logic [XLEN-1:0] resp_pc;      // PC of the next live (non-dropped) response
  logic [CW-1:0]   outstanding;  // accepted requests not yet answered
  logic [CW-1:0]   drop_count;   // of those, how many belong to a dead path
  logic [CW-1:0]   buf_count;
  logic            buf_full;
  logic            buf_empty;
  logic [FW-1:0]   head;
  logic            req_fire;
  logic            resp_live;
  logic            push;
  logic [CW-1:0]   out_next;
  logic [XLEN-1:0] redirect_target;
  logic            unused_bits;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit: every request in flight must be guaranteed a buffer slot
  assign imem_req_valid = reset_n &&
                          (({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are spurious and leave state untouched
  assign resp_live = imem_resp_valid && (outstanding != '0);
  assign out_next  = outstanding + CW'(req_fire) - CW'(resp_live);
  assign push      = resp_live && (drop_count == '0) && !redirect_valid;

  assign id_valid       = !buf_empty;
  assign id_pc          = head[FW-1:INSTR_WIDTH];
  assign id_instruction = head[INSTR_WIDTH-1:0];

  assign unused_bits = ^{redirect_pc[1:0], buf_full};

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({resp_pc, imem_resp_data}),
    .pop       (id_ready),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Fetch PC, in-flight accounting and stale-response discard on redirect
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      resp_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge (including a request
        // accepted right now) belongs to the old path
        fetch_pc   <= redirect_target;
        resp_pc    <= redirect_target;
        drop_count <= out_next;
      end else begin
        if (req_fire)                          fetch_pc   <= fetch_pc + XLEN'(4);
        if (resp_live && drop_count != '0)     drop_count <= drop_count - CW'(1);
        if (push)                              resp_pc    <= resp_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run.
// Reference: decode must see an unbroken +4 sequence from reset/each redirect
// target, each with the memory word for that PC; requests follow the same rule.
module tb_fetch_unit;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  int          delivered = 0;
  bit          rand_mode = 0;
  bit          mem_rand = 0;
  bit          mem_hold = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_req_addr = RST_PC;
  logic [31:0] exp_id_pc = RST_PC;
  bit          hold_prev = 0;
  logic [31:0] hold_pc, hold_ins;
  bit          wait_prev = 0;
  logic [31:0] wait_addr;
  bit          lst_fire, lst_pop, lst_req_valid, lst_id_valid;
  logic [31:0] lst_addr, lst_id_pc, lst_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check this cycle at negedge, advance the model, then drive
  // the next cycle's memory response and (in random mode) handshakes.
  task automatic cycle();
    logic fire, popd;
    @(negedge clock);
    fire = imem_req_valid && imem_req_ready;
    popd = id_valid && id_ready;
    lst_fire = fire; lst_pop = popd; lst_addr = imem_req_addr;
    lst_req_valid = imem_req_valid; lst_id_valid = id_valid;
    lst_id_pc = id_pc; lst_instr = id_instruction;
    if (fire) chk("req_addr", imem_req_addr, exp_req_addr);
    if (popd) begin
      chk("id_pc", id_pc, exp_id_pc);
      chk("id_instr", id_instruction, mem_word(exp_id_pc));
      delivered++;
    end
    if (hold_prev) chk("id_hold", {id_valid, id_pc, id_instruction}, {1'b1, hold_pc, hold_ins});
    if (wait_prev && reset_n) chk("addr_stable", {imem_req_valid, imem_req_addr}, {1'b1, wait_addr});
    if (imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (fire) begin
      mem_q.push_back(imem_req_addr);
      chk("credit", (mem_q.size() <= DEPTH), 1);
    end
    hold_prev = reset_n && id_valid && !id_ready && !redirect_valid;
    hold_pc = id_pc; hold_ins = id_instruction;
    wait_prev = reset_n && imem_req_valid && !imem_req_ready && !redirect_valid;
    wait_addr = imem_req_addr;
    if (popd) exp_id_pc = exp_id_pc + 32'd4;
    if (fire) exp_req_addr = exp_req_addr + 32'd4;
    if (redirect_valid) begin
      exp_id_pc    = {redirect_pc[31:2], 2'b00};
      exp_req_addr = {redirect_pc[31:2], 2'b00};
    end
    if (!reset_n) begin
      exp_id_pc = RST_PC; exp_req_addr = RST_PC; hold_prev = 0; wait_prev = 0;
    end
    @(posedge clock);
    #1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    if (mem_q.size() > 0 && !mem_hold && (!mem_rand || $urandom_range(0, 2) != 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0]);
    end
    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
      end
    end
  endtask

  // Two reset cycles; the memory forgets whatever was in flight
  task automatic do_reset();
    reset_n = 1'b0;
    mem_q.delete();
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic wait_id(input string tag, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      seen = lst_id_valid;
    end
    chk({tag, "_seen"}, seen, 1);
    if (seen) chk(tag, lst_id_pc, exp_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nfire;
    reset_n = 0; imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 1;

    // Reset state and basic streaming with 1-cycle memory
    do_reset();
    chk("rst_req_valid", lst_req_valid, 0);
    chk("rst_id_valid", lst_id_valid, 0);
    chk("rst_id_pc", lst_id_pc, 0);
    chk("rst_id_instr", lst_instr, 0);
    cycle(); chk("s1_req0", {lst_fire, lst_addr}, {1'b1, 32'h0});
    cycle(); chk("s1_req1", {lst_fire, lst_addr}, {1'b1, 32'h4});
             chk("s1_id_early", lst_id_valid, 0);
    cycle(); chk("s1_req2", {lst_fire, lst_addr}, {1'b1, 32'h8});
             chk("s1_id0", {lst_id_valid, lst_id_pc}, {1'b1, 32'h0});
    cycle(); chk("s1_id1", {lst_id_valid, lst_id_pc}, {1'b1, 32'h4});

    // Decode stalled: credit limit caps requests at DEPTH
    id_ready = 0;
    do_reset();
    nfire = 0;
    repeat (10) begin cycle(); nfire += int'(lst_fire); end
    chk("s2_fires", nfire, DEPTH);
    chk("s2_req_low", lst_req_valid, 0);
    chk("s2_head", {lst_id_valid, lst_id_pc}, {1'b1, 32'h0});
    id_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("s2_resume", {lst_id_valid, lst_id_pc}, {1'b1, 32'(i * 4)});
    end

    // Redirect with two requests outstanding
    mem_hold = 1;
    do_reset();
    cycle(); cycle();
    chk("s3_two_out", {lst_fire, lst_addr}, {1'b1, 32'h4});
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h103; mem_hold = 0;
    cycle();
    imem_req_ready = 1;
    cycle(); chk("s3_req_target", {lst_fire, lst_addr}, {1'b1, 32'h100});
    wait_id("s3_first_id", 32'h100);

    // Redirect together with a decode pop and a request acceptance
    do_reset();
    repeat (5) cycle();
    redirect_valid = 1; redirect_pc = 32'h200;
    cycle(); chk("s4_pop_and_fire", {lst_pop, lst_fire}, 2'b11);
    cycle(); chk("s4_id_low", lst_id_valid, 0);
    wait_id("s4_first_id", 32'h200);

    // PC wrap at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    cycle(); chk("s5_req_top", {lst_fire, lst_addr}, {1'b1, 32'hFFFF_FFFC});
    cycle(); chk("s5_req_wrap", {lst_fire, lst_addr}, {1'b1, 32'h0});
    wait_id("s5_id_top", 32'hFFFF_FFFC);
    cycle(); chk("s5_id_wrap", {lst_id_valid, lst_id_pc}, {1'b1, 32'h0});

    // One-cycle reset with three requests in flight; late responses arrive
    mem_hold = 1;
    do_reset();
    repeat (3) cycle();
    chk("s6_three_out", {lst_fire, lst_addr}, {1'b1, 32'h8});
    reset_n = 0; mem_hold = 0;
    cycle();
    chk("s6_rst_req_low", lst_req_valid, 0);
    reset_n = 1; imem_req_ready = 0;
    repeat (3) begin
      cycle();
      chk("s6_late_ignored", {lst_id_valid, lst_req_valid, lst_addr}, {1'b0, 1'b1, RST_PC});
    end
    imem_req_ready = 1;
    wait_id("s6_restart", RST_PC);

    // Randomized traffic against the reference stream
    do_reset();
    delivered = 0;
    rand_mode = 1; mem_rand = 1;
    repeat (2000) cycle();
    rand_mode = 0; redirect_valid = 0; imem_req_ready = 1; id_ready = 1;
    repeat (20) cycle();
    chk("rand_progress", (delivered > 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
